// File: rtl/seq_div.sv
`default_nettype none
// ============================================================================
//  Module      : seq_div
//  Description : Iterative unsigned integer divider for the execute stage.
//                Restoring shift-subtract, one quotient bit per clock, with
//                a start/busy/done handshake. Operand names match the
//                combinational multiplier so either unit can be selected.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    N            operand, quotient and remainder width (N >= 2)
//  Ports
//    clk          in   1  clock, rising edge
//    rst          in   1  asynchronous active-high reset
//    start        in   1  request, sampled only while not busy
//    rs1_reg      in   N  dividend (unsigned), captured on accept
//    rs2_reg      in   N  divisor (unsigned), captured on accept
//    busy         out  1  division in progress
//    done         out  1  one-cycle pulse, results valid
//    quo_rd       out  N  quotient
//    rem_rd       out  N  remainder
//    div_by_zero  out  1  last completed operation had divisor == 0
// ============================================================================
module seq_div #(
    parameter int unsigned N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] rs1_reg,
    input  logic [N-1:0] rs2_reg,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quo_rd,
    output logic [N-1:0] rem_rd,
    output logic         div_by_zero
);

    localparam int unsigned         c_cnt_w    = (N > 2) ? $clog2(N) : 1;
    localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CALC    = 2'd1,
        ST_DONE    = 2'd2,
        ST_DONE_DZ = 2'd3
    } state_t;

    state_t               r_state;
    logic                 r_busy;
    logic                 r_done;
    logic [N-1:0]         r_quo_rd;
    logic [N-1:0]         r_rem_rd;
    logic                 r_div_by_zero;
    logic [c_cnt_w-1:0]   r_count;
    logic [N-1:0]         r_rem;    // partial remainder R
    logic [N-1:0]         r_quo;    // dividend shifting out / quotient shifting in
    logic [N-1:0]         r_div;    // latched divisor D

    // Trial value: remainder shifted left with the next dividend bit.
    // It is N+1 bits so a divisor with its MSB set never overflows the compare.
    logic [N:0]           w_t;
    logic                 w_ge;
    logic [N-1:0]         w_diff;
    logic [N-1:0]         w_rem_next;
    logic [N-1:0]         w_quo_next;

    assign w_t        = {r_rem, r_quo[N-1]};
    assign w_ge       = (w_t >= {1'b0, r_div});
    // When T >= D the true difference is below D, so it fits in N bits and
    // modular N-bit subtraction of the low bits gives the exact result.
    assign w_diff     = w_t[N-1:0] - r_div;
    assign w_rem_next = w_ge ? w_diff : w_t[N-1:0];
    assign w_quo_next = {r_quo[N-2:0], w_ge};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_quo_rd      <= '0;
            r_rem_rd      <= '0;
            r_div_by_zero <= 1'b0;
            r_count       <= '0;
            r_rem         <= '0;
            r_quo         <= '0;
            r_div         <= '0;
        end else begin
            case (r_state)
                // DONE and DONE_DZ accept a new request exactly like IDLE,
                // which allows back-to-back issue without a bubble.
                ST_IDLE, ST_DONE, ST_DONE_DZ: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                    if (start) begin
                        if (rs2_reg != '0) begin
                            r_div   <= rs2_reg;
                            r_rem   <= '0;
                            r_quo   <= rs1_reg;
                            r_count <= '0;
                            r_busy  <= 1'b1;
                            r_state <= ST_CALC;
                        end else begin
                            // Divide by zero: result is ready on this edge.
                            r_quo         <= rs1_reg;
                            r_quo_rd      <= '1;
                            r_rem_rd      <= rs1_reg;
                            r_div_by_zero <= 1'b1;
                            r_done        <= 1'b1;
                            r_state       <= ST_DONE_DZ;
                        end
                    end
                end

                ST_CALC: begin
                    r_rem   <= w_rem_next;
                    r_quo   <= w_quo_next;
                    r_count <= r_count + 1'b1;
                    if (r_count == c_cnt_last) begin
                        r_quo_rd      <= w_quo_next;
                        r_rem_rd      <= w_rem_next;
                        r_div_by_zero <= 1'b0;
                        r_busy        <= 1'b0;
                        r_done        <= 1'b1;
                        r_state       <= ST_DONE;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quo_rd      = r_quo_rd;
    assign rem_rd      = r_rem_rd;
    assign div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire
